serial_frame_deser: RTL and testbench

//   Serial-to-parallel frame receiver. Sits directly downstream of ff_d_sinc and

---
 rtl/serial_frame_deser.sv | 133 +++++++++++++
 tb/tb_serial_frame_deser.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// -----------------------------------------------------------------------------
// serial_frame_deser
//   Serial-to-parallel frame receiver. Looks for a SYNC pattern in the serial
//   stream, then collects WIDTH payload bits MSB-first. The completed word is
//   presented on data_out with a single-cycle valid pulse. A modulo-256 count
//   of completed frames is kept.
//
// Ports
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   en         in   1       bit-sample enable
//   d          in   1       serial data in
//   data_out   out  WIDTH   last complete payload word, MSB = first bit received
//   valid      out  1       one-cycle pulse when data_out is updated
//   busy       out  1       high while collecting payload
//   frame_cnt  out  8       completed frame count, modulo 256
//
// States
//   state | meaning
//   HUNT  | sliding search for SYNC_PAT in the incoming bits
//   SHIFT | collecting WIDTH payload bits
// -----------------------------------------------------------------------------
module serial_frame_deser #(
    parameter int                WIDTH    = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {HUNT = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_q,     state_d;
    logic [SYNC_W-1:0]  hunt_sr_q,   hunt_sr_d;
    logic [WIDTH-1:0]   pay_sr_q,    pay_sr_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]   data_out_q,  data_out_d;
    logic               valid_q,     valid_d;
    logic               busy_q,      busy_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic [SYNC_W-1:0]  hunt_next;
    logic [WIDTH-1:0]   pay_next;
    logic               sync_hit;
    logic               last_bit;

    assign hunt_next = {hunt_sr_q[SYNC_W-2:0], d};
    assign pay_next  = {pay_sr_q[WIDTH-2:0], d};
    assign sync_hit  = (hunt_next == SYNC_PAT);
    assign last_bit  = (bit_cnt_q == CNT_W'(WIDTH - 1));

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            hunt_sr_q   <= '0;
            pay_sr_q    <= '0;
            bit_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hunt_sr_q   <= hunt_sr_d;
            pay_sr_q    <= pay_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (state_q == HUNT) begin
                if (sync_hit) state_d = SHIFT;
            end else begin
                if (last_bit) state_d = HUNT;
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        hunt_sr_d   = hunt_sr_q;
        pay_sr_d    = pay_sr_q;
        bit_cnt_d   = bit_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        if (en) begin
            if (state_q == HUNT) begin
                hunt_sr_d = hunt_next;
                if (sync_hit) begin
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end else begin
                pay_sr_d  = pay_next;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    data_out_d  = pay_next;
                    valid_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    busy_d      = 1'b0;
                    // Each frame needs a fresh sync; forget the old match.
                    hunt_sr_d   = '0;
                    bit_cnt_d   = '0;
                end
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
module tb_serial_frame_deser;

    localparam int         WIDTH  = 8;
    localparam int         SYNC_W = 4;
    localparam logic [3:0] PAT    = 4'b1011;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             d = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic [7:0]       frame_cnt;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int   hist[$];
    int   pay[$];
    bit   in_frame;
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_busy;
    int               exp_cnt;

    serial_frame_deser #(.WIDTH(WIDTH), .SYNC_W(SYNC_W), .SYNC_PAT(PAT)) dut (
        .clk(clk), .reset(reset), .en(en), .d(d),
        .data_out(data_out), .valid(valid), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC_W; i++) hist.push_back(0);
        pay.delete();
        in_frame  = 0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_cnt   = 0;
    endtask

    // One clock: drive en/d away from the edge, advance the model, settle.
    task automatic drive_bit(input logic e, input logic b);
        int v;
        int w;
        @(negedge clk);
        en = e;
        d  = b;
        @(posedge clk);
        exp_valid = 1'b0;
        if (e) begin
            if (!in_frame) begin
                hist.push_back(int'(b));
                void'(hist.pop_front());
                v = 0;
                foreach (hist[i]) v = v * 2 + hist[i];
                if (v == int'(PAT)) begin
                    in_frame = 1;
                    pay.delete();
                end
            end else begin
                pay.push_back(int'(b));
                if (pay.size() == WIDTH) begin
                    w = 0;
                    foreach (pay[i]) w = w * 2 + pay[i];
                    exp_data  = WIDTH'(w);
                    exp_valid = 1'b1;
                    exp_cnt   = (exp_cnt + 1) % 256;
                    in_frame  = 0;
                    hist.delete();
                    for (int i = 0; i < SYNC_W; i++) hist.push_back(0);
                end
            end
        end
        exp_busy = in_frame;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #2;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (data_out !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'h00) begin
            $display("FAIL reset_state: got data=%h valid=%b busy=%b cnt=%h, want 00/0/0/00",
                     data_out, valid, busy, frame_cnt);
        end else passes++;
    endtask

    task automatic test_basic();
        logic [11:0] seq = 12'b1011_1010_0101;
        do_reset();
        for (int i = 11; i >= 0; i--) begin
            drive_bit(1'b1, seq[i]);
            checks++;
            if (valid !== exp_valid || data_out !== exp_data || busy !== exp_busy || frame_cnt !== 8'(exp_cnt)) begin
                $display("FAIL basic bit%0d: got v=%b d=%h b=%b c=%h want v=%b d=%h b=%b c=%h", 11 - i,
                         valid, data_out, busy, frame_cnt, exp_valid, exp_data, exp_busy, 8'(exp_cnt));
            end else passes++;
            if (i == 8) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL basic_busy_after_sync: got %b want 1", busy);
                else passes++;
            end
        end
        checks++;
        if (valid !== 1'b1 || data_out !== 8'hA5 || frame_cnt !== 8'd1 || busy !== 1'b0)
            $display("FAIL basic_frame: got v=%b d=%h c=%h b=%b want 1/a5/01/0", valid, data_out, frame_cnt, busy);
        else passes++;
        drive_bit(1'b0, 1'b0);
        checks++;
        if (valid !== 1'b0 || data_out !== 8'hA5)
            $display("FAIL basic_pulse_width: got v=%b d=%h want 0/a5", valid, data_out);
        else passes++;
    endtask

    task automatic test_sliding();
        logic [14:0] seq = {7'b1101011, 8'h3C};
        do_reset();
        for (int i = 14; i >= 0; i--) begin
            drive_bit(1'b1, seq[i]);
            checks++;
            if (valid !== exp_valid || data_out !== exp_data || busy !== exp_busy || frame_cnt !== 8'(exp_cnt)) begin
                $display("FAIL sliding bit%0d: got v=%b d=%h b=%b c=%h want v=%b d=%h b=%b c=%h", 14 - i,
                         valid, data_out, busy, frame_cnt, exp_valid, exp_data, exp_busy, 8'(exp_cnt));
            end else passes++;
            if (i == 9 || i == 8) begin
                checks++;
                if (busy !== (i == 8)) $display("FAIL sliding_sync_bit%0d: busy got %b want %b", 14 - i, busy, i == 8);
                else passes++;
            end
        end
        checks++;
        if (data_out !== 8'h3C || frame_cnt !== 8'd1 || valid !== 1'b1)
            $display("FAIL sliding_frame: got d=%h c=%h v=%b want 3c/01/1", data_out, frame_cnt, valid);
        else passes++;
    endtask

    task automatic test_enable_gap();
        logic [14:0] seq = {4'b1011, 4'hF, 3'b101, 4'h0};
        logic [14:0] ena = {8'hFF, 3'b000, 4'hF};
        do_reset();
        for (int i = 14; i >= 0; i--) begin
            drive_bit(ena[i], seq[i]);
            checks++;
            if (valid !== exp_valid || data_out !== exp_data || busy !== exp_busy || frame_cnt !== 8'(exp_cnt)) begin
                $display("FAIL en_gap step%0d: got v=%b d=%h b=%b c=%h want v=%b d=%h b=%b c=%h", 14 - i,
                         valid, data_out, busy, frame_cnt, exp_valid, exp_data, exp_busy, 8'(exp_cnt));
            end else passes++;
            if (i >= 1) begin
                checks++;
                if (valid !== 1'b0) $display("FAIL en_gap_early_valid step%0d: got %b want 0", 14 - i, valid);
                else passes++;
            end
        end
        checks++;
        if (data_out !== 8'hF0 || valid !== 1'b1)
            $display("FAIL en_gap_frame: got d=%h v=%b want f0/1", data_out, valid);
        else passes++;
    endtask

    task automatic test_midreset();
        logic [8:0]  part = {4'b1011, 5'b10000};
        logic [11:0] full = {4'b1011, 8'h81};
        do_reset();
        for (int i = 8; i >= 0; i--) drive_bit(1'b1, part[i]);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || frame_cnt !== 8'd0)
            $display("FAIL midreset_async: got b=%b v=%b c=%h want 0/0/00", busy, valid, frame_cnt);
        else passes++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            drive_bit(1'b1, full[i]);
            checks++;
            if (valid !== exp_valid || data_out !== exp_data || busy !== exp_busy || frame_cnt !== 8'(exp_cnt)) begin
                $display("FAIL midreset bit%0d: got v=%b d=%h b=%b c=%h want v=%b d=%h b=%b c=%h", 11 - i,
                         valid, data_out, busy, frame_cnt, exp_valid, exp_data, exp_busy, 8'(exp_cnt));
            end else passes++;
        end
        checks++;
        if (data_out !== 8'h81 || frame_cnt !== 8'd1)
            $display("FAIL midreset_frame: got d=%h c=%h want 81/01", data_out, frame_cnt);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq = {4'b1011, 8'h12, 4'b1011, 8'h34, 8'hB0};
        int pulses = 0;
        do_reset();
        for (int i = 31; i >= 0; i--) begin
            drive_bit(1'b1, seq[i]);
            if (valid === 1'b1) pulses++;
            checks++;
            if (valid !== exp_valid || data_out !== exp_data || busy !== exp_busy || frame_cnt !== 8'(exp_cnt)) begin
                $display("FAIL b2b bit%0d: got v=%b d=%h b=%b c=%h want v=%b d=%h b=%b c=%h", 31 - i,
                         valid, data_out, busy, frame_cnt, exp_valid, exp_data, exp_busy, 8'(exp_cnt));
            end else passes++;
        end
        checks++;
        if (pulses != 2 || frame_cnt !== 8'd2 || data_out !== 8'h34)
            $display("FAIL b2b_summary: got pulses=%0d c=%h d=%h want 2/02/34", pulses, frame_cnt, data_out);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] w;
        do_reset();
        for (int f = 0; f < 256; f++) begin
            w = 8'($urandom);
            for (int i = 3; i >= 0; i--) drive_bit(1'b1, PAT[i]);
            for (int i = 7; i >= 0; i--) drive_bit(1'b1, w[i]);
            checks++;
            if (valid !== 1'b1 || data_out !== w || frame_cnt !== 8'(exp_cnt)) begin
                $display("FAIL wrap frame%0d: got v=%b d=%h c=%h want 1/%h/%h", f,
                         valid, data_out, frame_cnt, w, 8'(exp_cnt));
            end else passes++;
        end
        checks++;
        if (frame_cnt !== 8'd0) $display("FAIL wrap_to_zero: got %h want 00", frame_cnt);
        else passes++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive_bit(($urandom_range(0, 7) != 0), 1'($urandom));
            checks++;
            if (valid !== exp_valid || data_out !== exp_data || busy !== exp_busy || frame_cnt !== 8'(exp_cnt)) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc%0d: got v=%b d=%h b=%b c=%h want v=%b d=%h b=%b c=%h", n,
                             valid, data_out, busy, frame_cnt, exp_valid, exp_data, exp_busy, 8'(exp_cnt));
            end else passes++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_sliding();
        test_enable_gap();
        test_midreset();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
